// File: rtl/v_display_receiver_pkg.sv
// Shared constants for the display chunk path: chunk types, payload field
// offsets and the receiver FSM encoding (3 bits, same width as the transmitter).
package v_display_receiver_pkg;
  localparam logic [7:0] CHUNK_TYPE_TX_DISPLAY = 8'd6;
  localparam logic [7:0] CHUNK_TYPE_RX_DISPLAY = 8'd7;

  localparam int PAYLOAD_INDEX_LSB = 0;
  localparam int PAYLOAD_VALUE_LSB = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACK   = 3'd1,
    ST_WRITE = 3'd2
  } rx_state_e;

  function automatic logic [7:0] payload_index(input logic [15:0] b);
    return b[PAYLOAD_INDEX_LSB +: 8];
  endfunction

  function automatic logic [7:0] payload_value(input logic [15:0] b);
    return b[PAYLOAD_VALUE_LSB +: 8];
  endfunction
endpackage

// File: rtl/v_byte_buffer_write.sv
// Byte-addressed register array with single-byte write or full-buffer load.
// o_changed pulses the cycle after an update that altered the content.
module v_byte_buffer_write #(
  parameter int BYTES = 64,
  parameter int IDXW  = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               i_we,
  input  logic [IDXW-1:0]    i_idx,
  input  logic [7:0]         i_val,
  input  logic               i_load,
  input  logic [BYTES*8-1:0] i_load_data,
  output logic [BYTES*8-1:0] o_buf,
  output logic               o_changed
);
  logic [BYTES*8-1:0] r_buf;
  logic [BYTES*8-1:0] w_next;
  logic               r_changed;

  always_comb begin
    w_next = r_buf;
    if (i_load) begin
      w_next = i_load_data;
    end else if (i_we) begin
      for (int i = 0; i < BYTES; i++) begin
        if (i_idx == IDXW'(i)) w_next[i*8 +: 8] = i_val;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_buf     <= '0;
      r_changed <= 1'b0;
    end else begin
      r_buf     <= w_next;
      r_changed <= (w_next != r_buf);
    end
  end

  assign o_buf     = r_buf;
  assign o_changed = r_changed;
endmodule

// File: rtl/v_display_receiver.sv
// Consumes display RX chunks (index, value) and writes them into a byte buffer.
// Define V_DISPLAY_RECEIVER_COMMIT_EN for shadow/visible double buffering.
module v_display_receiver
  import v_display_receiver_pkg::*;
#(
  parameter logic [7:0] INTERFACE_RX_CHUNK_TYPE   = CHUNK_TYPE_RX_DISPLAY,
  parameter int         DISPLAY_BUFFER_BYTE_SIZE  = 64,
  parameter int         DISPLAY_BUFFER_INDEX_SIZE = 8
`ifdef V_DISPLAY_RECEIVER_COMMIT_EN
  ,
  parameter logic [7:0] COMMIT_INDEX              = 8'hFF
`endif
) (
  input  logic                                  CLK,
  input  logic                                  RST_N,
  input  logic                                  rx_chunk_valid,
  input  logic [7:0]                            rx_chunk_type,
  input  logic [15:0]                           rx_chunk_bytes,
  output logic                                  rx_chunk_ack,
  output logic [DISPLAY_BUFFER_BYTE_SIZE*8-1:0] display,
  output logic                                  display_updated,
  output logic [7:0]                            write_error_count
);
  localparam int         BYTES = DISPLAY_BUFFER_BYTE_SIZE;
  localparam int         IDXW  = DISPLAY_BUFFER_INDEX_SIZE;
  localparam logic [7:0] SIZE8 = 8'(BYTES);

  rx_state_e  r_state, w_state_nxt;
  logic [7:0] r_idx, r_val, r_err;
  logic       w_match, w_in_range, w_commit, w_wr, w_err_inc;

  assign w_match    = rx_chunk_valid && (rx_chunk_type == INTERFACE_RX_CHUNK_TYPE);
  assign w_in_range = (r_idx < SIZE8);
`ifdef V_DISPLAY_RECEIVER_COMMIT_EN
  assign w_commit   = (r_idx == COMMIT_INDEX);
`else
  assign w_commit   = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_val   <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_match) begin
        r_idx <= payload_index(rx_chunk_bytes);
        r_val <= payload_value(rx_chunk_bytes);
      end
      if (w_err_inc && r_err != 8'hFF) r_err <= r_err + 8'd1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    rx_chunk_ack = 1'b0;
    w_wr         = 1'b0;
    w_err_inc    = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_match) w_state_nxt = ST_ACK;
      ST_ACK: begin
        rx_chunk_ack = 1'b1;
        w_state_nxt  = ST_WRITE;
      end
      ST_WRITE: begin
        // Commit marker takes priority even if it happens to be in range.
        if (!w_commit) begin
          w_wr      = w_in_range;
          w_err_inc = !w_in_range;
        end
        w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef V_DISPLAY_RECEIVER_COMMIT_EN
  logic [BYTES*8-1:0] w_shadow;
  logic               w_shadow_chg;

  v_byte_buffer_write #(.BYTES(BYTES), .IDXW(IDXW)) u_shadow (
    .CLK(CLK), .RST_N(RST_N),
    .i_we(w_wr), .i_idx(r_idx[IDXW-1:0]), .i_val(r_val),
    .i_load(1'b0), .i_load_data('0),
    .o_buf(w_shadow), .o_changed(w_shadow_chg)
  );

  v_byte_buffer_write #(.BYTES(BYTES), .IDXW(IDXW)) u_visible (
    .CLK(CLK), .RST_N(RST_N),
    .i_we(1'b0), .i_idx('0), .i_val('0),
    .i_load(r_state == ST_WRITE && w_commit), .i_load_data(w_shadow),
    .o_buf(display), .o_changed(display_updated)
  );
`else
  v_byte_buffer_write #(.BYTES(BYTES), .IDXW(IDXW)) u_visible (
    .CLK(CLK), .RST_N(RST_N),
    .i_we(w_wr), .i_idx(r_idx[IDXW-1:0]), .i_val(r_val),
    .i_load(1'b0), .i_load_data('0),
    .o_buf(display), .o_changed(display_updated)
  );
`endif

  assign write_error_count = r_err;
endmodule

// File: doc/v_display_receiver.md
Name: v_display_receiver

Overview:
- Host-to-device counterpart of the display chunk transmitter: consumes RX chunks arriving from the UART chunk decoder and writes them into a byte-addressed display buffer.
- Chunk payload format: bytes[7:0] = byte index, bytes[15:8] = byte value, identical to the TX display chunk.
- Sits between the RX chunk demultiplexer and any logic that reads a host-driven display or frame buffer.
- Accepts only chunks of its configured type; all other chunk types are left for other consumers.

Parameters:
- INTERFACE_RX_CHUNK_TYPE, 7: chunk type byte this block accepts.
- DISPLAY_BUFFER_BYTE_SIZE, 64: buffer size in bytes; legal range 1..255.
- DISPLAY_BUFFER_INDEX_SIZE, 8: index width in bits; must be ≥ clog2(DISPLAY_BUFFER_BYTE_SIZE) and ≤ 8.
- COMMIT_INDEX, 8'hFF: index value reserved as the frame-commit marker (used only with the optional feature).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset; asynchronous assert, active-low.
- rx_chunk_valid  in  1  source has a chunk on type/bytes; held until acked.
- rx_chunk_type  in  8  chunk type.
- rx_chunk_bytes  in  16  chunk payload.
- rx_chunk_ack  out  1  one-cycle pulse: chunk consumed.
- display  out  DISPLAY_BUFFER_BYTE_SIZE*8  visible buffer; byte i at [i*8 +: 8].
- display_updated  out  1  one-cycle pulse when the visible buffer content changes.
- write_error_count  out  8  saturating count of dropped out-of-range writes.

Behaviour:
- Reset (RST_N low, any cycle, including mid-transaction):
  - FSM forced to IDLE; rx_chunk_ack=0, display_updated=0, write_error_count=0.
  - Visible buffer and shadow buffer cleared to 0; any in-flight chunk is discarded.
- FSM states: IDLE, ACK, WRITE.
  - IDLE: if rx_chunk_valid and rx_chunk_type==INTERFACE_RX_CHUNK_TYPE, latch index=bytes[7:0] and value=bytes[15:8]; go to ACK. Valid with any other type: stay in IDLE, no ack.
  - ACK: rx_chunk_ack=1 for exactly this cycle; go to WRITE.
  - WRITE: apply the latched write (rules below); go to IDLE.
- Source rule: valid, type and bytes are stable until ack is seen; the source deasserts valid, or presents the next chunk, on the cycle after ack. Because WRITE separates ACK from IDLE, a chunk is never consumed twice.
- Throughput: one chunk per 3 cycles. Ack is asserted 1 cycle after valid is first sampled in IDLE.
- Write rules in WRITE:
  - index < DISPLAY_BUFFER_BYTE_SIZE: write value to the target byte.
  - Otherwise (and not the commit marker when the feature is enabled): drop the write; write_error_count += 1, saturating at 255.
- display_updated: pulses in the cycle after the visible buffer is written, only if the new content differs from the old. Rewriting the same value gives no pulse.
- Simultaneous events: reset wins over everything. A non-matching-type chunk stays un-acked indefinitely, which is not an error for this block.

Optional Feature:
- Macro: V_DISPLAY_RECEIVER_COMMIT_EN.
- Defined (double buffering):
  - Writes go to the shadow buffer only.
  - A chunk with index==COMMIT_INDEX copies shadow to visible in its WRITE cycle; display_updated pulses if the visible content changed.
  - The commit chunk's value byte is ignored; the commit chunk never increments write_error_count.
- Undefined:
  - No shadow buffer; writes go directly to the visible buffer.
  - COMMIT_INDEX is treated as an ordinary index (out of range if ≥ size).

Decomposition:
- Shared package holds:
  - chunk type constants, including INTERFACE_RX_CHUNK_TYPE alongside the existing TX display type;
  - the payload field offsets (index [7:0], value [15:8]);
  - the FSM state encodings (3-bit, matching the transmitter's width).
- One sub-module is natural: v_byte_buffer_write, a byte-addressed register array with write enable and a changed flag. Instantiate it once for the visible buffer and once for the shadow buffer.

Test Plan:
- Reset then chunk type=7, bytes=16'hA505 → ack 1 cycle later; display[5*8 +: 8]=8'hA5; display_updated pulses once; all other bytes 0.
- Same chunk repeated → ack; display unchanged; no display_updated pulse.
- Chunk type=6, bytes=16'h1102, valid held 10 cycles → no ack; display unchanged.
- Chunk bytes=16'h3340 (index 64) → ack; display unchanged; write_error_count=1. Repeat 300 times → count saturates at 255.
- COMMIT_EN: write index 0=8'h11 and index 1=8'h22 → display still 0. Then bytes=16'h00FF → display bytes 0,1 = 11,22; one display_updated pulse.
- Assert RST_N low during the ACK state of a valid chunk → ack drops immediately; after release display=0, state IDLE; the re-presented chunk is acked normally.
